// File: rtl/j_dspbus_sched.sv
// Round-robin owner scheduler for the DSP local-bus port: one-hot grant,
// per-grant burst limit and a single dead turnaround cycle between owners.
module j_dspbus_sched #(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            beat,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_id,
    output logic            busy,
    output logic [2:0]      burst_cnt
);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t          state_reg;
    logic [1:0]      last_id_reg;
    logic [NREQ-1:0] gnt_reg;
    logic [1:0]      gnt_id_reg;
    logic            busy_reg;
    logic [2:0]      burst_cnt_reg;
    logic [2:0]      burst_cnt_next;

    logic [1:0]      cand_idx [NREQ];
    logic [NREQ-1:0] cand_hit;
    logic [1:0]      win_id;
    logic            win_any;
    logic [NREQ-1:0] win_onehot;
    logic            owner_req;
    logic            last_beat;
    logic            release_now;

    // Candidate sums stay below 2*NREQ, so one conditional subtract wraps them.
    function automatic logic [1:0] wrap_idx(input logic [2:0] s);
        logic [2:0] r;
        r = (s >= 3'(NREQ)) ? (s - 3'(NREQ)) : s;
        return r[1:0];
    endfunction

    // Search order last_id+1, last_id+2, ..., last_id; slot NREQ-1 is last_id itself.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi]   = wrap_idx({1'b0, last_id_reg} + 3'(gi + 1));
            assign cand_hit[gi]   = req[cand_idx[gi]];
            assign win_onehot[gi] = (win_id == 2'(gi));
        end
    endgenerate

    always_comb begin
        win_id  = '0;
        win_any = |cand_hit;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_id = cand_idx[k];
            end
        end
    end

    assign owner_req      = req[gnt_id_reg];
    assign burst_cnt_next = burst_cnt_reg + 3'd1;
    assign last_beat      = beat && (burst_cnt_reg == 3'(MAXBURST - 1));
    assign release_now    = !owner_req || last_beat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            last_id_reg   <= 2'(NREQ - 1);
            gnt_reg       <= '0;
            gnt_id_reg    <= '0;
            busy_reg      <= 1'b0;
            burst_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE, TURN: begin
                    if (win_any) begin
                        state_reg     <= OWN;
                        gnt_reg       <= win_onehot;
                        gnt_id_reg    <= win_id;
                        last_id_reg   <= win_id;
                        busy_reg      <= 1'b1;
                        burst_cnt_reg <= '0;
                    end else begin
                        state_reg <= IDLE;
                        gnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end
                end
                OWN: begin
                    // The releasing beat is still counted; the count then
                    // holds until the next grant clears it.
                    if (beat) begin
                        burst_cnt_reg <= burst_cnt_next;
                    end
                    if (release_now) begin
                        state_reg <= TURN;
                        gnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign busy      = busy_reg;
    assign burst_cnt = burst_cnt_reg;

endmodule

// File: tb/tb_j_dspbus_sched.sv
// Cycle-by-cycle vector bench for j_dspbus_sched with MAXBURST=8 and MAXBURST=4
// instances sharing one set of inputs.
module tb_j_dspbus_sched;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       beat;

    logic [3:0] gnt8, gnt4;
    logic [1:0] gnt_id8, gnt_id4;
    logic       busy8, busy4;
    logic [2:0] cnt8, cnt4;

    int tests;
    int fails;

    j_dspbus_sched #(.NREQ(4), .MAXBURST(8)) dut8 (
        .clk(clk), .reset(reset), .req(req), .beat(beat),
        .gnt(gnt8), .gnt_id(gnt_id8), .busy(busy8), .burst_cnt(cnt8)
    );

    j_dspbus_sched #(.NREQ(4), .MAXBURST(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .beat(beat),
        .gnt(gnt4), .gnt_id(gnt_id4), .busy(busy4), .burst_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;   // 0: MAXBURST=8 instance, 1: MAXBURST=4 instance
        logic       rst;
        logic [3:0] req;
        logic       beat;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic sel, input logic rst, input logic [3:0] rq, input logic bt,
                       input logic [3:0] g, input logic [1:0] id, input logic b, input logic [2:0] c);
        vec_t v;
        v.sel = sel; v.rst = rst; v.req = rq; v.beat = bt;
        v.gnt = g; v.id = id; v.busy = b; v.cnt = c;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        int   gap;
        logic [1:0] old_id;

        tests = 0;
        fails = 0;
        reset = 1'b1;
        req   = 4'h0;
        beat  = 1'b0;

        // Reset, single request, three beats, owner drop with req[2] pending.
        add(0, 1, 4'h0, 0, 4'h0, 2'd0, 0, 3'd0);
        add(0, 0, 4'h1, 0, 4'h1, 2'd0, 1, 3'd0);
        add(0, 0, 4'h1, 1, 4'h1, 2'd0, 1, 3'd1);
        add(0, 0, 4'h1, 1, 4'h1, 2'd0, 1, 3'd2);
        add(0, 0, 4'h1, 1, 4'h1, 2'd0, 1, 3'd3);
        add(0, 0, 4'h4, 0, 4'h0, 2'd0, 0, 3'd3);
        add(0, 0, 4'h4, 0, 4'h4, 2'd2, 1, 3'd0);
        add(0, 0, 4'h0, 0, 4'h0, 2'd2, 0, 3'd0);
        add(0, 0, 4'h0, 1, 4'h0, 2'd2, 0, 3'd0);
        add(0, 0, 4'h0, 1, 4'h0, 2'd2, 0, 3'd0);

        // Full rotation with all requesting and a beat every cycle.
        add(0, 1, 4'hF, 1, 4'h0, 2'd0, 0, 3'd0);
        add(0, 0, 4'hF, 1, 4'h1, 2'd0, 1, 3'd0);
        for (int k = 1; k < 8; k++) add(0, 0, 4'hF, 1, 4'h1, 2'd0, 1, 3'(k));
        add(0, 0, 4'hF, 1, 4'h0, 2'd0, 0, 3'd0);
        for (int o = 1; o <= 4; o++) begin
            add(0, 0, 4'hF, 1, 4'(1 << (o % 4)), 2'(o % 4), 1, 3'd0);
            for (int k = 1; k < 8; k++) add(0, 0, 4'hF, 1, 4'(1 << (o % 4)), 2'(o % 4), 1, 3'(k));
            add(0, 0, 4'hF, 1, 4'h0, 2'(o % 4), 0, 3'd0);
        end

        // Owner 2 reaches count 5, then reset overrides everything.
        add(0, 0, 4'h4, 0, 4'h4, 2'd2, 1, 3'd0);
        for (int k = 1; k <= 5; k++) add(0, 0, 4'hF, 1, 4'h4, 2'd2, 1, 3'(k));
        add(0, 1, 4'hF, 1, 4'h0, 2'd0, 0, 3'd0);
        add(0, 0, 4'hF, 0, 4'h1, 2'd0, 1, 3'd0);

        // Final beat together with owner drop, then re-raise during TURN goes last.
        for (int k = 1; k < 8; k++) add(0, 0, 4'hF, 1, 4'h1, 2'd0, 1, 3'(k));
        add(0, 0, 4'hE, 1, 4'h0, 2'd0, 0, 3'd0);
        add(0, 0, 4'hE, 0, 4'h2, 2'd1, 1, 3'd0);
        add(0, 0, 4'hE, 1, 4'h2, 2'd1, 1, 3'd1);
        add(0, 0, 4'hC, 0, 4'h0, 2'd1, 0, 3'd1);
        add(0, 0, 4'hE, 0, 4'h4, 2'd2, 1, 3'd0);

        // MAXBURST=4: beat every other cycle, sole requester re-granted.
        add(1, 1, 4'h0, 0, 4'h0, 2'd0, 0, 3'd0);
        add(1, 0, 4'h2, 0, 4'h2, 2'd1, 1, 3'd0);
        add(1, 0, 4'h2, 0, 4'h2, 2'd1, 1, 3'd0);
        add(1, 0, 4'h2, 1, 4'h2, 2'd1, 1, 3'd1);
        add(1, 0, 4'h2, 0, 4'h2, 2'd1, 1, 3'd1);
        add(1, 0, 4'h2, 1, 4'h2, 2'd1, 1, 3'd2);
        add(1, 0, 4'h2, 0, 4'h2, 2'd1, 1, 3'd2);
        add(1, 0, 4'h2, 1, 4'h2, 2'd1, 1, 3'd3);
        add(1, 0, 4'h2, 0, 4'h2, 2'd1, 1, 3'd3);
        add(1, 0, 4'h2, 1, 4'h0, 2'd1, 0, 3'd4);
        add(1, 0, 4'h2, 1, 4'h2, 2'd1, 1, 3'd0);
        // Final beat with req drop, then beats in TURN and IDLE are ignored.
        add(1, 0, 4'h2, 1, 4'h2, 2'd1, 1, 3'd1);
        add(1, 0, 4'h2, 1, 4'h2, 2'd1, 1, 3'd2);
        add(1, 0, 4'h2, 1, 4'h2, 2'd1, 1, 3'd3);
        add(1, 0, 4'h0, 1, 4'h0, 2'd1, 0, 3'd4);
        add(1, 0, 4'h0, 1, 4'h0, 2'd1, 0, 3'd4);
        add(1, 0, 4'h0, 1, 4'h0, 2'd1, 0, 3'd4);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst;
            req   = tbl[i].req;
            beat  = tbl[i].beat;
            tick();
            if (tbl[i].sel == 1'b0) begin
                check("gnt8", i, gnt8, tbl[i].gnt);
                check("gnt_id8", i, 4'(gnt_id8), 4'(tbl[i].id));
                check("busy8", i, 4'(busy8), 4'(tbl[i].busy));
                check("cnt8", i, 4'(cnt8), 4'(tbl[i].cnt));
                $display("[TB] step %0d mb8 rst=%b req=%h beat=%b -> gnt=%h id=%0d busy=%b cnt=%0d",
                         i, reset, req, beat, gnt8, gnt_id8, busy8, cnt8);
            end else begin
                check("gnt4", i, gnt4, tbl[i].gnt);
                check("gnt_id4", i, 4'(gnt_id4), 4'(tbl[i].id));
                check("busy4", i, 4'(busy4), 4'(tbl[i].busy));
                check("cnt4", i, 4'(cnt4), 4'(tbl[i].cnt));
                $display("[TB] step %0d mb4 rst=%b req=%h beat=%b -> gnt=%h id=%0d busy=%b cnt=%0d",
                         i, reset, req, beat, gnt4, gnt_id4, busy4, cnt4);
            end
        end

        // Hand-written: measure the dead gap between consecutive owners.
        @(negedge clk);
        reset = 1'b1; req = 4'hF; beat = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (gnt8 == 4'h0 && n < 20) begin tick(); n++; end
        check("gap_first_grant", 0, 4'(gnt8 != 4'h0), 4'd1);
        check("gap_onehot", 0, 4'($onehot(gnt8)), 4'd1);
        old_id = gnt_id8;
        n = 0;
        while (gnt8 != 4'h0 && n < 20) begin tick(); n++; end
        check("gap_release", 0, 4'(gnt8 == 4'h0), 4'd1);
        check("gap_hold_len", 0, 4'(n), 4'd8);
        gap = 0;
        while (gnt8 == 4'h0 && gap < 5) begin tick(); gap++; end
        check("gap_len", 0, 4'(gap), 4'd1);
        check("gap_next_id", 0, 4'(gnt_id8), 4'(old_id + 2'd1));
        $display("[TB] gap sequence: first id=%0d hold=%0d gap=%0d next id=%0d", old_id, n, gap, gnt_id8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
